// File: rtl/multi_seg_ctrl.sv
// multi_seg_ctrl -- control FSM for the multi-cycle R/I/J CPU datapath.
//
// Steps each instruction through fetch, decode, execute, memory and
// write-back. It drives every datapath enable and mux select from the IR
// fields and the ALU flags.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   opcode, funct        IR[31:26], IR[5:0]
//   ZF, OF               ALU zero / signed-overflow flags (current cycle)
//   PC_Write, PC_Src     PC load enable and source select
//   IorD, Mem_Write      memory address select, memory write enable
//   IR_Write             instruction register load enable
//   Reg_Write, RegDst    register file write enable, destination select
//   MemToReg             write-back data select
//   ALU_SrcA, ALU_SrcB   ALU operand selects
//   ALU_OP               ALU operation
//   state                current state (debug)
//   halted               high while parked in HALT
//   illegal              one-cycle pulse in DECODE for unsupported encodings
module multi_seg_ctrl #(
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ZF,
  input  logic       OF,
  output logic       PC_Write,
  output logic [1:0] PC_Src,
  output logic       IorD,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [3:0] ALU_OP,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R   = 4'd2,
                         S_WB_R  = 4'd3,  S_EXEC_I = 4'd4,  S_WB_I     = 4'd5,
                         S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7, S_WB_LW   = 4'd8,
                         S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP     = 4'd11,
                         S_HALT  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000,
                         OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100,
                         OP_ORI   = 6'b001101, OP_XORI = 6'b001110,
                         OP_LW    = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101,
                         OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001,
                         F_SUB = 6'b100010, F_SUBU = 6'b100011,
                         F_AND = 6'b100100, F_OR   = 6'b100101,
                         F_XOR = 6'b100110, F_NOR  = 6'b100111,
                         F_SLT = 6'b101010, F_SLTU = 6'b101011,
                         F_SLLV = 6'b000100;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_XOR = 4'd2, A_NOR = 4'd3,
                         A_ADD = 4'd4, A_SUB = 4'd5, A_SLT = 4'd6,
                         A_SLTU = 4'd7, A_SLLV = 4'd8;

  function automatic logic legal_funct(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
      F_XOR, F_NOR, F_SLT, F_SLTU, F_SLLV: legal_funct = 1'b1;
      default:                             legal_funct = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU: r_alu_op = A_ADD;
      F_SUB, F_SUBU: r_alu_op = A_SUB;
      F_AND:         r_alu_op = A_AND;
      F_OR:          r_alu_op = A_OR;
      F_XOR:         r_alu_op = A_XOR;
      F_NOR:         r_alu_op = A_NOR;
      F_SLT:         r_alu_op = A_SLT;
      F_SLTU:        r_alu_op = A_SLTU;
      F_SLLV:        r_alu_op = A_SLLV;
      default:       r_alu_op = A_AND;
    endcase
  endfunction

  function automatic logic [3:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: i_alu_op = A_ADD;
      OP_SLTI: i_alu_op = A_SLT;
      OP_ANDI: i_alu_op = A_AND;
      OP_ORI:  i_alu_op = A_OR;
      OP_XORI: i_alu_op = A_XOR;
      default: i_alu_op = A_AND;
    endcase
  endfunction

  logic [3:0] state_q, next_state;
  logic       ovf;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ovf     <= 1'b0;
    end else begin
      state_q <= next_state;
      // Trapping arithmetic only; overflow of the unsigned variants is ignored.
      if (state_q == S_EXEC_R)
        ovf <= OF & ((funct == F_ADD) || (funct == F_SUB));
      else if (state_q == S_EXEC_I)
        ovf <= OF & (opcode == OP_ADDI);
    end
  end

  always_comb begin
    next_state  = state_q;
    pc_write_c  = 1'b0;
    PC_Src      = 2'd0;
    IorD        = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALU_SrcA    = 1'b0;
    ALU_SrcB    = 2'd0;
    ALU_OP      = A_AND;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        ALU_SrcB   = 2'd1;
        ALU_OP     = A_ADD;
        pc_write_c = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (sext(imm) << 2) is formed here.
        ALU_SrcB = 2'd2;
        ALU_OP   = A_ADD;
        if (opcode == HALT_OPCODE)
          next_state = S_HALT;
        else if (opcode == OP_RTYPE && legal_funct(funct))
          next_state = S_EXEC_R;
        else if (opcode inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI})
          next_state = S_EXEC_I;
        else if (opcode inside {OP_LW, OP_SW})
          next_state = S_MEM_ADDR;
        else if (opcode inside {OP_BEQ, OP_BNE})
          next_state = S_BRANCH;
        else if (opcode == OP_J)
          next_state = S_JUMP;
        else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALU_SrcA   = 1'b1;
        ALU_OP     = r_alu_op(funct);
        next_state = S_WB_R;
      end
      S_WB_R: begin
        reg_write_c = ~ovf;
        RegDst      = 1'b1;
        next_state  = S_FETCH;
      end
      S_EXEC_I: begin
        ALU_SrcA   = 1'b1;
        ALU_SrcB   = (opcode inside {OP_ANDI, OP_ORI, OP_XORI}) ? 2'd3 : 2'd2;
        ALU_OP     = i_alu_op(opcode);
        next_state = S_WB_I;
      end
      S_WB_I: begin
        reg_write_c = ~ovf;
        next_state  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALU_SrcA   = 1'b1;
        ALU_SrcB   = 2'd2;
        ALU_OP     = A_ADD;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD       = 1'b1;
        next_state = S_WB_LW;
      end
      S_WB_LW: begin
        reg_write_c = 1'b1;
        MemToReg    = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEM_WR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SrcA   = 1'b1;
        ALU_OP     = A_SUB;
        PC_Src     = 2'd1;
        pc_write_c = ((opcode == OP_BEQ) & ZF) | ((opcode == OP_BNE) & ~ZF);
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PC_Src     = 2'd2;
        pc_write_c = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Reset holds the FSM in FETCH, whose enables would otherwise be active.
  assign PC_Write  = pc_write_c  & ~rst;
  assign Mem_Write = mem_write_c & ~rst;
  assign IR_Write  = ir_write_c  & ~rst;
  assign Reg_Write = reg_write_c & ~rst;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multi_seg_ctrl.sv
module tb_multi_seg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       ZF, OF;
  logic       PC_Write, IorD, Mem_Write, IR_Write, Reg_Write, RegDst, MemToReg, ALU_SrcA;
  logic [1:0] PC_Src, ALU_SrcB;
  logic [3:0] ALU_OP, state;
  logic       halted, illegal;

  multi_seg_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ZF(ZF), .OF(OF),
    .PC_Write(PC_Write), .PC_Src(PC_Src), .IorD(IorD), .Mem_Write(Mem_Write),
    .IR_Write(IR_Write), .Reg_Write(Reg_Write), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_OP(ALU_OP), .state(state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [17:0] ctl_obs;
  assign ctl_obs = {PC_Write, PC_Src, IorD, Mem_Write, IR_Write, Reg_Write, RegDst,
                    MemToReg, ALU_SrcA, ALU_SrcB, ALU_OP, halted, illegal};

  function automatic logic [17:0] ctl(input logic pcw, input logic [1:0] pcsrc,
      input logic iord, input logic memw, input logic irw, input logic regw,
      input logic regdst, input logic m2r, input logic srca, input logic [1:0] srcb,
      input logic [3:0] aluop, input logic hlt, input logic ill);
    return {pcw, pcsrc, iord, memw, irw, regw, regdst, m2r, srca, srcb, aluop, hlt, ill};
  endfunction

  // Reference: instruction classes and ALU operations from the ISA tables.
  localparam logic [5:0] HALT_OP = 6'b111111;
  logic [5:0] r_functs [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04};
  logic [5:0] i_ops [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
  logic [5:0] known_ops [12] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  function automatic logic [3:0] ref_r_op(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'd4;
      6'h22, 6'h23: return 4'd5;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h26: return 4'd2;
      6'h27: return 4'd3;
      6'h2A: return 4'd6;
      6'h2B: return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] ref_i_op(input logic [5:0] op);
    case (op)
      6'h08: return 4'd4;
      6'h0A: return 4'd6;
      6'h0C: return 4'd0;
      6'h0D: return 4'd1;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic is_legal_funct(input logic [5:0] f);
    foreach (r_functs[i]) if (r_functs[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input string tag, input int exp_st, input logic [17:0] exp_ctl,
                      input logic zf, input logic of);
    @(negedge clk);
    ZF = zf;
    OF = of;
    #1;
    chk({tag, ".state"}, 32'(state), 32'(exp_st));
    chk({tag, ".ctl"}, 32'(ctl_obs), 32'(exp_ctl));
  endtask

  // Runs one instruction cycle by cycle; abort_memrd asserts rst in MEM_RD.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit abort_memrd);
    logic zf, of, ovf_m, ill;
    zf = 1'($urandom);
    of = 1'($urandom);
    @(negedge clk);
    opcode = op;
    funct  = fn;
    ZF = zf;
    OF = of;
    #1;
    chk("fetch.state", 32'(state), 32'd0);
    chk("fetch.ctl", 32'(ctl_obs), 32'(ctl(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0)));
    ill = !((op == 6'h00 && is_legal_funct(fn)) || (op != 6'h00 && (op inside {known_ops})));
    step("decode", 1, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 0, ill), 1'($urandom), 1'($urandom));
    if (ill) return;
    if (op == HALT_OP) begin
      for (int i = 0; i < 20; i++)
        step("halt", 15, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'($urandom), 1'($urandom));
    end else if (op == 6'h00) begin
      of = 1'($urandom);
      ovf_m = of & (fn == 6'h20 || fn == 6'h22);
      step("exec_r", 2, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ref_r_op(fn), 0, 0), 1'($urandom), of);
      step("wb_r", 3, ctl(0, 0, 0, 0, 0, !ovf_m, 1, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
    end else if (op inside {i_ops}) begin
      of = 1'($urandom);
      ovf_m = of & (op == 6'h08);
      step("exec_i", 4, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, (op inside {6'h0C, 6'h0D, 6'h0E}) ? 2'd3 : 2'd2,
                            ref_i_op(op), 0, 0), 1'($urandom), of);
      step("wb_i", 5, ctl(0, 0, 0, 0, 0, !ovf_m, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
    end else if (op == 6'h23 || op == 6'h2B) begin
      step("mem_addr", 6, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0), 1'($urandom), 1'($urandom));
      if (op == 6'h23) begin
        step("mem_rd", 7, ctl(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
        if (abort_memrd) begin
          #2 rst = 1'b1;
          #1;
          chk("abort.state", 32'(state), 32'd0);
          chk("abort.en", 32'({PC_Write, IR_Write, Reg_Write, Mem_Write, halted}), 32'd0);
          @(negedge clk);
          #1;
          chk("abort.hold.state", 32'(state), 32'd0);
          chk("abort.hold.en", 32'({PC_Write, IR_Write, Reg_Write, Mem_Write, halted, illegal}), 32'd0);
          @(posedge clk);
          #2 rst = 1'b0;
          return;
        end
        step("wb_lw", 8, ctl(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
      end else begin
        step("mem_wr", 9, ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      zf = 1'($urandom);
      step(op == 6'h04 ? "beq" : "bne", 10,
           ctl((op == 6'h04) ? zf : !zf, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0), zf, 1'($urandom));
    end else begin
      step("jump", 11, ctl(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    int k;
    k  = $urandom_range(0, 9);
    fn = 6'($urandom);
    case (k)
      0, 9: begin op = 6'h00; fn = r_functs[$urandom_range(0, 10)]; end
      1: op = i_ops[$urandom_range(0, 4)];
      2: op = 6'h23;
      3: op = 6'h2B;
      4: op = 6'h04;
      5: op = 6'h05;
      6: op = 6'h02;
      7: begin
        op = 6'($urandom);
        while (op inside {known_ops}) op = 6'($urandom);
      end
      default: begin
        op = 6'h00;
        while (is_legal_funct(fn)) fn = 6'($urandom);
      end
    endcase
    run_instr(op, fn, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h20;
    ZF = 1'b0;
    OF = 1'b0;
    #3;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.en", 32'({PC_Write, IR_Write, Reg_Write, Mem_Write, halted, illegal}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hold.state", 32'(state), 32'd0);
    chk("reset.hold.en", 32'({PC_Write, IR_Write, Reg_Write, Mem_Write}), 32'd0);
    #1 rst = 1'b0;

    // Directed: add, addi, lw, sw, beq/bne, j, illegal opcode.
    run_instr(6'h00, 6'h20, 1'b0);
    run_instr(6'h08, 6'h01, 1'b0);
    run_instr(6'h23, 6'h10, 1'b0);
    run_instr(6'h2B, 6'h10, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h11, 6'h00, 1'b0);

    for (int n = 0; n < 300; n++) run_random();

    // Reset taken in the middle of a load, then normal operation again.
    run_instr(6'h23, 6'h10, 1'b1);
    for (int n = 0; n < 20; n++) run_random();

    // HALT parks the machine until reset.
    run_instr(HALT_OP, 6'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("halt.reset.state", 32'(state), 32'd0);
    chk("halt.reset.halted", 32'(halted), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_instr(6'h00, 6'h22, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_seg_ctrl.md
# multi_seg_ctrl

Control state machine for the multi-cycle R/I/J CPU datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps, and drives every datapath enable and mux select from the latched instruction fields and the ALU flags. It sits beside the datapath inside the top-level CPU and is the only source of register, memory, IR and PC write enables.

## Interface
- HALT_OPCODE, 6'b111111, opcode that parks the machine in HALT
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- ZF  in  1  ALU zero flag (combinational, current cycle)
- OF  in  1  ALU signed-overflow flag (combinational, current cycle)
- PC_Write  out  1  PC load enable
- PC_Src  out  2  0: ALU result (PC+4), 1: branch target register, 2: jump target {PC[31:28],IR[25:0],2'b00}
- IorD  out  1  memory address select, 0: PC, 1: ALU result register
- Mem_Write  out  1  data memory write enable
- IR_Write  out  1  instruction register load enable
- Reg_Write  out  1  register file write enable
- RegDst  out  1  0: rt, 1: rd
- MemToReg  out  1  0: ALU result register, 1: memory data register
- ALU_SrcA  out  1  0: PC, 1: register A
- ALU_SrcB  out  2  0: register B, 1: constant 4, 2: sign-extended imm, 3: zero-extended imm (andi/ori/xori); branch offset uses sign-ext imm << 2 via 2 in DECODE
- ALU_OP  out  4  0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 SLT, 7 SLTU, 8 SLLV
- state  out  4  current state encoding (debug)
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct

## Operation
- States: FETCH 0, DECODE 1, EXEC_R 2, WB_R 3, EXEC_I 4, WB_I 5, MEM_ADDR 6, MEM_RD 7, WB_LW 8, MEM_WR 9, BRANCH 10, JUMP 11, HALT 15.
- FETCH: IorD=0, IR_Write=1, ALU_SrcA=0, ALU_SrcB=1, ALU_OP=ADD, PC_Src=0, PC_Write=1 -> DECODE.
- DECODE: ALU_SrcA=0, ALU_SrcB=2 shifted, ALU_OP=ADD (branch target latched). Dispatch: opcode 0 with legal funct -> EXEC_R; addi 001000/slti 001010/andi 001100/ori 001101/xori 001110 -> EXEC_I; lw 100011/sw 101011 -> MEM_ADDR; beq 000100/bne 000101 -> BRANCH; j 000010 -> JUMP; HALT_OPCODE -> HALT; anything else -> illegal=1, FETCH (executes as NOP).
- Legal funct: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 000100 sllv.
- EXEC_R / EXEC_I: ALU_SrcA=1, ALU_SrcB=0 (R) or 2/3 (I), ALU_OP from funct/opcode. Internal ovf register captures OF when instruction is add, sub or addi; cleared otherwise.
- WB_R / WB_I: Reg_Write=~ovf, RegDst=1 (R)/0 (I), MemToReg=0 -> FETCH. Overflowing add/sub/addi leave register file unchanged.
- MEM_ADDR: ALU_SrcA=1, ALU_SrcB=2, ADD -> MEM_RD (lw) or MEM_WR (sw). MEM_RD: IorD=1 -> WB_LW. WB_LW: Reg_Write=1, RegDst=0, MemToReg=1 -> FETCH. MEM_WR: IorD=1, Mem_Write=1 -> FETCH.
- BRANCH: ALU_SrcA=1, ALU_SrcB=0, SUB, PC_Src=1, PC_Write=(beq&ZF)|(bne&~ZF) (Mealy on ZF) -> FETCH.
- JUMP: PC_Src=2, PC_Write=1 -> FETCH. HALT: all enables 0, halted=1, remains until rst.
- All enables not listed for a state are 0; selects not listed are 0.

## Timing
- Reset: state=FETCH, ovf=0, halted=0, illegal=0; all write enables forced 0 while rst=1. First fetch on first rising edge after rst falls.
- Cycles per instruction: R/I 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- rst asserted mid-instruction: state returns to FETCH immediately (async); no partial write occurs after assertion.
- ZF/OF sampled only in BRANCH and EXEC states; ignored elsewhere.

## Test plan
- add $3,$1,$2 with $1=5,$2=7 -> states 0,1,2,3,0; Reg_Write high only in WB_R; $3=12.
- addi with $1=0x7FFFFFFF, imm=1 -> OF=1 in EXEC_I; Reg_Write=0 in WB_I; target unchanged.
- lw then sw at address 0x10 -> lw 5 cycles with IorD=1 in MEM_RD, sw Mem_Write high exactly 1 cycle.
- beq with equal regs (ZF=1) -> PC_Write in BRANCH; with ZF=0 -> no PC_Write; bne inverse.
- j 0x0000040 -> PC_Src=2, PC_Write=1 in JUMP; opcode 6'b010001 -> illegal pulse, back to FETCH.
- HALT_OPCODE -> halted=1, no enables for 20 cycles; rst pulse mid-MEM_RD -> state=0 immediately, enables 0 during reset.
